// File: rtl/seg_pkg.sv
// Shared constants for the 8-digit seven-segment scanner.
// Latency: none, constants and a pure combinational helper only.
// Backpressure: not applicable.
package seg_pkg;

  localparam int         DIGITS  = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low gfedcba patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Index of the most significant nonzero nibble; 0 when the word is zero,
  // so digit 0 always stays lit and a zero word shows a single "0".
  function automatic logic [2:0] top_nonzero_digit(input logic [31:0] word);
    logic [2:0] top;
    top = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (word[4*i +: 4] != 4'h0) top = 3'(i);
    end
    return top;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low seven-segment pattern (gfedcba).
// Latency: purely combinational.
// Backpressure: not applicable.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG[nib];

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed 8-digit hex display scanner with frame-atomic value updates.
// Latency: an_n/seg_n registered one cycle after cnt/idx/shadow; loads commit at the next frame boundary.
// Backpressure: none; load always accepted, a newer load overwrites an uncommitted one.
// Config: define SEG_LZ_BLANK_EN to switch off leading-zero digits.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        load,
  input  logic        blank,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n,
  output logic        frame_done,
  output logic        updated
);

  // Slot length in clocks; must be at least 4 and larger than BLANK_CYC.
  localparam int               DIV       = CLK_HZ / SCAN_HZ;
  localparam int               CNT_W     = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [2:0]       IDX_LAST  = 3'(DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      pend_q, pend_d;
  logic             pend_flag_q, pend_flag_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [7:0]       an_n_q, an_n_d;
  logic [7:0]       seg_n_q, seg_n_d;
  logic             frame_done_q, frame_done_d;
  logic             updated_q, updated_d;

  logic             tick;
  logic             frame_end;
  logic             commit;
  logic [3:0]       digit_nib;
  logic [6:0]       digit_seg;
  logic             lz_ok;
  logic             digit_on;

  // Slot divider and digit index; frame ends on the last clock of digit 7
  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    frame_end = tick && (idx_q == IDX_LAST);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = tick ? idx_q + 3'd1 : idx_q;
  end

  // Double-buffered value: loads park in pending, shadow only changes at frame ends
  always_comb begin
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    shadow_d    = shadow_q;
    commit      = 1'b0;
    if (frame_end) begin
      // A load landing on the boundary is newer than anything pending
      commit      = load | pend_flag_q;
      pend_flag_d = 1'b0;
      if (load) begin
        shadow_d = value;
      end else if (pend_flag_q) begin
        shadow_d = pend_q;
      end
    end else if (load) begin
      pend_d      = value;
      pend_flag_d = 1'b1;
    end
    updated_d    = commit;
    frame_done_d = frame_end;
  end

  assign digit_nib = shadow_q[{idx_q, 2'b00} +: 4];

  seg_hex_decode u_hex (
    .nib   (digit_nib),
    .seg_n (digit_seg)
  );

  // Digit drive: dark during the anti-ghost window, while blanked, or for leading zeros
  always_comb begin
`ifdef SEG_LZ_BLANK_EN
    lz_ok = (idx_q <= top_nonzero_digit(shadow_q));
`else
    lz_ok = 1'b1;
`endif
    digit_on = !blank && (cnt_q >= CNT_BLANK) && lz_ok;
    an_n_d   = SEG_OFF;
    seg_n_d  = SEG_OFF;
    if (digit_on) begin
      an_n_d  = ~(8'b1 << idx_q);
      seg_n_d = {1'b1, digit_seg};
    end
  end

  // State and output registers; reset discards pending and displayed data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      pend_q       <= 32'd0;
      pend_flag_q  <= 1'b0;
      shadow_q     <= 32'd0;
      an_n_q       <= SEG_OFF;
      seg_n_q      <= SEG_OFF;
      frame_done_q <= 1'b0;
      updated_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
      shadow_q     <= shadow_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      frame_done_q <= frame_done_d;
      updated_q    <= updated_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign frame_done = frame_done_q;
  assign updated    = updated_q;

endmodule

// File: doc/seg_display_scan.md
SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter SCAN_HZ, default 1000, meaning the per-digit refresh rate; DIV = CLK_HZ/SCAN_HZ, and DIV >= 4.
REQ-003 SHALL have parameter BLANK_CYC, default 16, meaning anti-ghost blank cycles at the start of each digit slot; 1 <= BLANK_CYC < DIV.
REQ-004 SHALL have port clk, input, 1, the clock.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port value, input, 32, the CPU result word to display as 8 hex digits.
REQ-007 SHALL have port load, input, 1, a one-cycle strobe that captures value.
REQ-008 SHALL have port blank, input, 1, a level input that forces all digits off.
REQ-009 SHALL have port seg_n, output, 8, active-low segments; [6:0]=gfedcba, [7]=dp.
REQ-010 SHALL have port an_n, output, 8, active-low digit enables; bit i drives digit i (digit 0 = LS nibble).
REQ-011 SHALL have port frame_done, output, 1, a one-cycle pulse at each frame boundary.
REQ-012 SHALL have port updated, output, 1, a one-cycle pulse when a new value is committed to display.

Function
REQ-013 SHALL run divider cnt 0..DIV-1 and wrap to 0; tick = (cnt==DIV-1).
REQ-014 SHALL advance digit index idx (3 bits) on tick and wrap 7->0; frame boundary = tick with idx==7.
REQ-015 SHALL capture value into a pending register and set pend_flag on load; a later load before commit overwrites pending.
REQ-016 SHALL, at a frame boundary with pend_flag set, copy pending to shadow, clear pend_flag, and pulse updated the next cycle; frames never mix two values.
REQ-017 SHALL, when load coincides with a frame boundary, commit the loaded value directly to shadow, leave pend_flag clear, and pulse updated.
REQ-018 SHALL decode nibble shadow[4*idx+3 -: 4] through the hex table: 0->7'h40, 1->7'h79, 8->7'h00, A->7'h08, F->7'h0E (active-low gfedcba); seg_n[7]=1 always.
REQ-019 SHALL register an_n/seg_n, with 1-cycle latency from cnt/idx/shadow.
REQ-020 SHALL drive an_n = ~(1<<idx) when cnt >= BLANK_CYC and blank==0; otherwise an_n=8'hFF and seg_n=8'hFF.
REQ-021 SHALL keep the scan running while blank is asserted; blank affects only outputs.
REQ-022 SHALL register frame_done, high for exactly one cycle after each frame boundary.

Reset
REQ-023 SHALL, on rst, asynchronously set cnt=0, idx=0, pending=0, shadow=0, pend_flag=0, an_n=8'hFF, seg_n=8'hFF, frame_done=0, updated=0.
REQ-024 SHALL, on rst mid-frame, discard pending and shadow data; display resumes with 0 in all digits at digit 0 after release.

Configuration
REQ-025 SHALL, with macro SEG_LZ_BLANK_EN defined, hold an_n[i] high for every digit i above the most significant nonzero shadow nibble; digit 0 always enabled; shadow==0 shows a single "0".
REQ-026 SHALL, without SEG_LZ_BLANK_EN, enable all 8 digits per REQ-020.

Structure
REQ-027 SHALL place DIGITS=8, the 16-entry hex segment table, and SEG_OFF=8'hFF in a shared package seg_pkg.
REQ-028 SHALL implement hex decode as the combinational sub-module seg_hex_decode (4-bit in, 7-bit active-low out).

Verification (bench params CLK_HZ=800, SCAN_HZ=100 -> DIV=8, BLANK_CYC=2)
REQ-029 SHALL cover: reset release -> an_n=8'hFF for 3 cycles, then an_n=8'hFE, seg_n=8'hC0.
REQ-030 SHALL cover: load 32'h0000_00A1 mid-frame -> digits unchanged until frame boundary; next frame digit0 seg_n=8'hF9, digit1 seg_n=8'h88; updated pulses once.
REQ-031 SHALL cover: two loads (32'h1, then 32'h8) in one frame -> only 32'h8 is committed, with one updated pulse.
REQ-032 SHALL cover: load on the frame-boundary cycle -> value committed the same boundary, and updated pulses.
REQ-033 SHALL cover: blank=1 for 2 frames -> an_n=8'hFF throughout; frame_done still pulses every 64 cycles.
REQ-034 SHALL cover: SEG_LZ_BLANK_EN, value 32'h0000_0F00 -> an_n bits 7..3 stay high; digits 2..0 scan.
